// File: rtl/big_cell_blitter_if.sv
// Command and BIG-RAM port bundle for big_cell_blitter.
// slave = blitter side, master = game logic / RAM side.
interface big_cell_blitter_if #(
  parameter int unsigned DataW = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [4:0]       cmd_row;
  logic [5:0]       cmd_col;
  logic [15:0]      cmd_shape;
  logic [DataW-1:0] cmd_color;
  logic             en;
  logic             big_wr_en;
  logic [10:0]      big_wr_addr;
  logic [DataW-1:0] big_wr_data;
  logic [10:0]      big_rd_addr;
  logic [DataW-1:0] big_rd_data;
  logic             busy;
  logic             done;
  logic             collision;

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_shape, cmd_color, en, big_rd_data,
    output cmd_ready, big_wr_en, big_wr_addr, big_wr_data, big_rd_addr, busy, done, collision
  );

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_shape, cmd_color, en, big_rd_data,
    input  cmd_ready, big_wr_en, big_wr_addr, big_wr_data, big_rd_addr, busy, done, collision
  );
endinterface

// File: rtl/big_cell_blitter.sv
// Command-driven cell writer for the BIG board RAM: 4x4 mask draw/erase and whole-board fill.
// Optional pre-draw collision check is compiled in with BLITTER_COLLISION_CHECK_EN.
module big_cell_blitter #(
  parameter int unsigned Rows  = 30,
  parameter int unsigned Cols  = 40,
  parameter int unsigned DataW = 6
) (
  input logic               clk_i,
  input logic               rst_ni,
  big_cell_blitter_if.slave bus_io
);

  localparam logic [5:0] RowsW   = 6'(Rows);
  localparam logic [6:0] ColsW   = 7'(Cols);
  localparam logic [4:0] RowLast = 5'(Rows - 1);
  localparam logic [5:0] ColLast = 6'(Cols - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StClear,
    StDone
`ifdef BLITTER_COLLISION_CHECK_EN
    , StCheck
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic [15:0]      shape_q, shape_d;
  logic [3:0]       k_q, k_d;
  logic             pend_q, pend_d;
  logic [10:0]      addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic             collision_q, collision_d;
  logic [11:0]      slot_nxt;

  // Returns {in_bounds, addr} for slot k; row/col sums are one bit wider so they never wrap.
  function automatic logic [11:0] slot_fn(input logic [4:0] r, input logic [5:0] c,
                                          input logic [3:0] k);
    logic [5:0] tr;
    logic [6:0] tc;
    tr = {1'b0, r} + {4'd0, k[3:2]};
    tc = {1'b0, c} + {5'd0, k[1:0]};
    return {(tr < RowsW) && (tc < ColsW), tr[4:0], tc[5:0]};
  endfunction

`ifdef BLITTER_COLLISION_CHECK_EN
  logic [4:0]  chk_q, chk_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [11:0] slot_prv;
  logic [3:0]  prv_k;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^bus_io.big_rd_data;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    shape_d     = shape_q;
    k_d         = k_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    data_d      = data_q;
    collision_d = collision_q;
    slot_nxt    = '0;
`ifdef BLITTER_COLLISION_CHECK_EN
    chk_d       = chk_q;
    rd_addr_d   = rd_addr_q;
    prv_k       = chk_q[3:0] - 4'd1;
    slot_prv    = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          row_d       = bus_io.cmd_row;
          col_d       = bus_io.cmd_col;
          shape_d     = bus_io.cmd_shape;
          k_d         = '0;
          collision_d = 1'b0;
          data_d      = (bus_io.cmd_op == 2'b00 || bus_io.cmd_op == 2'b11) ?
                        bus_io.cmd_color : '0;
          if (bus_io.cmd_op[1]) begin
            state_d = StClear;
            pend_d  = 1'b1;
            addr_d  = '0;
          end else begin
            slot_nxt = slot_fn(bus_io.cmd_row, bus_io.cmd_col, 4'd0);
`ifdef BLITTER_COLLISION_CHECK_EN
            if (bus_io.cmd_op == 2'b00) begin
              state_d   = StCheck;
              chk_d     = '0;
              rd_addr_d = slot_nxt[10:0];
            end else
`endif
            begin
              state_d = StDraw;
              pend_d  = bus_io.cmd_shape[0] & slot_nxt[11];
              addr_d  = slot_nxt[10:0];
            end
          end
        end
      end
      StDraw: begin
        if (bus_io.en) begin
          if (k_q == 4'hf) begin
            state_d = StDone;
            pend_d  = 1'b0;
          end else begin
            k_d      = k_q + 4'd1;
            slot_nxt = slot_fn(row_q, col_q, k_d);
            pend_d   = shape_q[k_d] & slot_nxt[11];
            addr_d   = slot_nxt[10:0];
          end
        end
      end
      StClear: begin
        if (bus_io.en) begin
          if (addr_q[5:0] == ColLast) begin
            if (addr_q[10:6] == RowLast) begin
              state_d = StDone;
              pend_d  = 1'b0;
            end else begin
              addr_d = {addr_q[10:6] + 5'd1, 6'd0};
            end
          end else begin
            addr_d[5:0] = addr_q[5:0] + 6'd1;
          end
        end
      end
`ifdef BLITTER_COLLISION_CHECK_EN
      StCheck: begin
        // Read data for the slot issued last cycle arrives now.
        slot_prv = slot_fn(row_q, col_q, prv_k);
        if (chk_q != 5'd0 && shape_q[prv_k] &&
            (!slot_prv[11] || bus_io.big_rd_data != '0)) begin
          collision_d = 1'b1;
        end
        if (chk_q == 5'd16) begin
          if (collision_d) begin
            state_d = StDone;
          end else begin
            state_d  = StDraw;
            k_d      = '0;
            slot_nxt = slot_fn(row_q, col_q, 4'd0);
            pend_d   = shape_q[0] & slot_nxt[11];
            addr_d   = slot_nxt[10:0];
          end
        end else begin
          chk_d     = chk_q + 5'd1;
          slot_nxt  = slot_fn(row_q, col_q, chk_q[3:0] + 4'd1);
          rd_addr_d = slot_nxt[10:0];
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      shape_q     <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      collision_q <= 1'b0;
`ifdef BLITTER_COLLISION_CHECK_EN
      chk_q       <= '0;
      rd_addr_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      shape_q     <= shape_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      collision_q <= collision_d;
`ifdef BLITTER_COLLISION_CHECK_EN
      chk_q       <= chk_d;
      rd_addr_q   <= rd_addr_d;
`endif
    end
  end

  // pend_q marks the current slot as writable; en only decides whether it is consumed now.
  assign bus_io.big_wr_en   = pend_q & bus_io.en;
  assign bus_io.big_wr_addr = addr_q;
  assign bus_io.big_wr_data = data_q;
  assign bus_io.cmd_ready   = (state_q == StIdle) & rst_ni;
  assign bus_io.busy        = (state_q != StIdle) && (state_q != StDone);
  assign bus_io.done        = (state_q == StDone);
`ifdef BLITTER_COLLISION_CHECK_EN
  assign bus_io.big_rd_addr = rd_addr_q;
  assign bus_io.collision   = collision_q;
`else
  assign bus_io.big_rd_addr = '0;
  assign bus_io.collision   = 1'b0;
`endif

endmodule

// File: tb/tb_big_cell_blitter.sv
// Directed, table-driven bench for big_cell_blitter with a behavioural BIG RAM.
module tb_big_cell_blitter;

`ifdef BLITTER_COLLISION_CHECK_EN
  localparam bit Feat = 1'b1;
`else
  localparam bit Feat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  big_cell_blitter_if #(.DataW(6)) bif ();

  big_cell_blitter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bif)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BIG RAM model: synchronous write, 1-cycle read latency.
  logic [5:0]  mem [2048];
  logic        mem_clr = 1'b1;
  logic        pl_we = 1'b0;
  logic [10:0] pl_a = '0;
  logic [5:0]  pl_d = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
    end else if (bif.big_wr_en === 1'b1) begin
      mem[bif.big_wr_addr] <= bif.big_wr_data;
    end else if (pl_we) begin
      mem[pl_a] <= pl_d;
    end
    bif.big_rd_data <= mem[bif.big_rd_addr];
  end

  logic [16:0] wq [$];
  logic [16:0] exq [$];
  int en_viol = 0;
  always @(negedge clk) begin
    if (bif.big_wr_en === 1'b1) begin
      wq.push_back({bif.big_wr_addr, bif.big_wr_data});
      if (bif.en !== 1'b1) en_viol = en_viol + 1;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic build_exp(input logic [1:0] op, input int row, input int col,
                           input logic [15:0] shape, input logic [5:0] color);
    exq.delete();
    if (op[1]) begin
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 40; c++)
          exq.push_back({5'(r), 6'(c), (op[0] ? color : 6'd0)});
    end else begin
      for (int lr = 0; lr < 4; lr++)
        for (int lc = 0; lc < 4; lc++)
          if (shape[lr*4+lc] && row + lr < 30 && col + lc < 40)
            exq.push_back({5'(row + lr), 6'(col + lc), (op == 2'b00 ? color : 6'd0)});
    end
  endtask

  function automatic bit model_coll(input int row, input int col, input logic [15:0] shape);
    logic [10:0] a;
    for (int lr = 0; lr < 4; lr++)
      for (int lc = 0; lc < 4; lc++)
        if (shape[lr*4+lc]) begin
          if (row + lr >= 30 || col + lc >= 40) return 1'b1;
          a = {5'(row + lr), 6'(col + lc)};
          if (mem[a] != 6'd0) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic preload(input int r, input int c, input logic [5:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1;
    pl_a  = {5'(r), 6'(c)};
    pl_d  = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issue one command, wait for done, check latency, writes, collision and return to idle.
  task automatic do_cmd(input string nm, input logic [1:0] op, input int row, input int col,
                        input logic [15:0] shape, input logic [5:0] color, input bit tog,
                        input int exp_n);
    bit coll;
    int exp_lat, c0, lat, bad, n_exp;
    bit got;
    coll = (Feat && op == 2'b00) ? model_coll(row, col, shape) : 1'b0;
    build_exp(op, row, col, shape, color);
    if (coll) exq.delete();
    n_exp = coll ? 0 : exp_n;
    if (op[1]) exp_lat = 1201;
    else exp_lat = tog ? 32 : 17;
    if (Feat && op == 2'b00) exp_lat = coll ? 18 : 17 + (tog ? 33 : 17);

    @(posedge clk); #1;
    wq.delete();
    en_viol = 0;
    bif.cmd_op    = op;
    bif.cmd_row   = 5'(row);
    bif.cmd_col   = 6'(col);
    bif.cmd_shape = shape;
    bif.cmd_color = color;
    bif.cmd_valid = 1'b1;
    bif.en        = tog ? 1'b0 : 1'b1;
    @(negedge clk);
    chk({nm, ".ready"}, int'(bif.cmd_ready), 1);
    c0 = cyc;
    @(posedge clk); #1;
    // Scrambled fields with valid still high must be ignored while busy.
    bif.cmd_op    = ~op;
    bif.cmd_row   = 5'(row + 1);
    bif.cmd_col   = 6'(col + 2);
    bif.cmd_shape = ~shape;
    bif.cmd_color = ~color;
    if (tog) bif.en = ~bif.en;
    got = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bif.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (n >= 2) bif.cmd_valid = 1'b0;
      if (tog) bif.en = ~bif.en;
    end
    bif.cmd_valid = 1'b0;
    chk({nm, ".done_seen"}, int'(got), 1);
    lat = cyc - c0;
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".collision"}, int'(bif.collision), int'(coll));
    chk({nm, ".busy_at_done"}, int'(bif.busy), 0);
    chk({nm, ".wr_count"}, wq.size(), n_exp);
    bad = 0;
    for (int i = 0; i < wq.size() && i < exq.size(); i++)
      if (wq[i] !== exq[i]) bad++;
    bad += (wq.size() > exq.size()) ? wq.size() - exq.size() : exq.size() - wq.size();
    chk({nm, ".wr_content"}, bad, 0);
    chk({nm, ".en_gate"}, en_viol, 0);
    @(posedge clk); #1;
    bif.en = 1'b1;
    @(negedge clk);
    chk({nm, ".done_pulse"}, int'(bif.done), 0);
    chk({nm, ".ready_after"}, int'(bif.cmd_ready), 1);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  op;
    int          row;
    int          col;
    logic [15:0] shape;
    logic [5:0]  color;
    bit          tog;
    int          exp_n;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int nw;
    bit got;
    vecs[0]  = '{"bar_draw",     2'b00,  5, 10, 16'h0F00, 6'h3F, 1'b0,    4};
    vecs[1]  = '{"bar_erase",    2'b01,  5, 10, 16'h0F00, 6'h3F, 1'b0,    4};
    vecs[2]  = '{"bar_draw_tog", 2'b00,  5, 10, 16'h0F00, 6'h3F, 1'b1,    4};
    vecs[3]  = '{"bar_erase_tog",2'b01,  5, 10, 16'h0F00, 6'h00, 1'b1,    4};
    vecs[4]  = '{"corner_draw",  2'b00, 28, 38, 16'hFFFF, 6'h3F, 1'b0,    4};
    vecs[5]  = '{"corner_erase", 2'b01, 28, 38, 16'hFFFF, 6'h00, 1'b0,    4};
    vecs[6]  = '{"t_draw_00",    2'b00,  0,  0, 16'h004E, 6'h2A, 1'b0,    4};
    vecs[7]  = '{"bottom_clip",  2'b00, 29,  0, 16'h1111, 6'h01, 1'b0,    1};
    vecs[8]  = '{"right_clip",   2'b00,  0, 37, 16'h000F, 6'h07, 1'b0,    3};
    vecs[9]  = '{"fill_all",     2'b11,  0,  0, 16'h0000, 6'h15, 1'b0, 1200};
    vecs[10] = '{"erase_on_fill",2'b01, 10, 20, 16'h0660, 6'h00, 1'b0,    4};
    vecs[11] = '{"clear_all",    2'b10,  0,  0, 16'h0000, 6'h2A, 1'b0, 1200};

    rst_n         = 1'b0;
    bif.en        = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_op    = '0;
    bif.cmd_row   = '0;
    bif.cmd_col   = '0;
    bif.cmd_shape = '0;
    bif.cmd_color = '0;
    #1;
    chk("rst.ready_low", int'(bif.cmd_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    bif.en  = 1'b1;
    @(negedge clk);
    chk("rst.ready",     int'(bif.cmd_ready), 1);
    chk("rst.wr_en",     int'(bif.big_wr_en), 0);
    chk("rst.wr_addr",   int'(bif.big_wr_addr), 0);
    chk("rst.wr_data",   int'(bif.big_wr_data), 0);
    chk("rst.rd_addr",   int'(bif.big_rd_addr), 0);
    chk("rst.busy",      int'(bif.busy), 0);
    chk("rst.done",      int'(bif.done), 0);
    chk("rst.collision", int'(bif.collision), 0);

    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i].nm, vecs[i].op, vecs[i].row, vecs[i].col, vecs[i].shape,
             vecs[i].color, vecs[i].tog, vecs[i].exp_n);
      if (i == 10) begin
        @(posedge clk); #1;
        chk("mem.erased_11_21", int'(mem[{5'd11, 6'd21}]), 0);
        chk("mem.erased_12_22", int'(mem[{5'd12, 6'd22}]), 0);
        chk("mem.kept_10_20",   int'(mem[{5'd10, 6'd20}]), 'h15);
        chk("mem.kept_13_23",   int'(mem[{5'd13, 6'd23}]), 'h15);
        chk("mem.kept_29_39",   int'(mem[{5'd29, 6'd39}]), 'h15);
      end
    end

    // Occupied cell under the bar: collision only when the check is compiled in.
    preload(6, 11, 6'h03);
    do_cmd("pre_occupied", 2'b00, 5, 10, 16'h0F00, 6'h3F, 1'b0, 4);
    chk("pre_occupied.coll_flag", int'(bif.collision), int'(Feat));
    do_cmd("pre_cleanup", 2'b01, 5, 10, 16'h0F00, 6'h00, 1'b0, 4);
    preload(6, 11, 6'h00);
    do_cmd("pre_empty", 2'b00, 5, 10, 16'h0F00, 6'h3F, 1'b0, 4);
    chk("pre_empty.coll_flag", int'(bif.collision), 0);

    // Reset in the middle of a fill.
    @(posedge clk); #1;
    wq.delete();
    bif.cmd_op    = 2'b11;
    bif.cmd_color = 6'h15;
    bif.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (wq.size() >= 100) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort.reached_100", int'(got), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.wr_en", int'(bif.big_wr_en), 0);
    chk("abort.busy",  int'(bif.busy), 0);
    nw = wq.size();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort.no_writes", wq.size(), nw);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort.ready", int'(bif.cmd_ready), 1);
    chk("abort.busy_after", int'(bif.busy), 0);
    do_cmd("post_abort_clear", 2'b10, 0, 0, 16'h0000, 6'h00, 1'b0, 1200);
    do_cmd("post_abort_draw", 2'b00, 12, 30, 16'h0033, 6'h0C, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
